// File: rtl/fetch_sequencer_pkg.sv
// ----------------------------------------------------------------------------
// fetch_sequencer_pkg
//   Shared definitions for the IF-stage fetch sequencer: default widths,
//   default reset PC, default response timeout and the sequencer state type.
// ----------------------------------------------------------------------------
package fetch_sequencer_pkg;

   localparam int unsigned XLEN_DEF     = 32;
   localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
   localparam int unsigned TIMEOUT_DEF  = 16;

   // IDLE: one settling cycle after reset, REQ: request on the bus,
   // WAIT: granted and waiting for rvalid, HOLD: data buffered behind an ID stall.
   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_WAIT = 2'd2,
      S_HOLD = 2'd3
   } fetch_state_e;

endpackage

// File: rtl/fetch_sequencer_if.sv
// ----------------------------------------------------------------------------
// fetch_sequencer_if
//   Instruction-memory req/gnt/rvalid bus.
//   req    : fetch request (master -> slave)
//   addr   : word-aligned fetch address (master -> slave)
//   gnt    : request accepted this cycle (slave -> master)
//   rvalid : read data valid, one per granted request (slave -> master)
//   rdata  : instruction word (slave -> master)
// ----------------------------------------------------------------------------
interface fetch_sequencer_if
   import fetch_sequencer_pkg::*;
#(
   parameter int unsigned XLEN = XLEN_DEF
) ();

   logic            req;
   logic [XLEN-1:0] addr;
   logic            gnt;
   logic            rvalid;
   logic [XLEN-1:0] rdata;

   modport master (output req, output addr, input gnt, input rvalid, input rdata);
   modport slave  (input req, input addr, output gnt, output rvalid, output rdata);

endinterface

// File: rtl/fetch_sequencer.sv
// ----------------------------------------------------------------------------
// fetch_sequencer
//   IF-stage controller: owns the PC, issues one outstanding fetch at a time
//   over the imem bus and hands delivered instructions to the IF/ID register.
//   Ports:
//     clk, reset      : clock, asynchronous active-high reset
//     id_stall        : ID cannot accept; buffered instruction is held
//     branch_taken    : one-cycle redirect pulse from EX
//     branch_target   : redirect PC (low bits forced to zero)
//     imem            : instruction memory bus (master side)
//     IF_ID_write     : IF/ID loads fetch_pc/fetch_inst this cycle
//     IF_flush        : IF/ID clears this cycle (combinational on redirect)
//     fetch_pc/inst   : last delivered instruction and its PC
//     misalign_err    : pulse after a redirect to a non-word-aligned target
//     bus_err         : sticky, response not received within TIMEOUT_CYCLES
// ----------------------------------------------------------------------------
module fetch_sequencer
   import fetch_sequencer_pkg::*;
#(
   parameter int unsigned     XLEN           = XLEN_DEF,
   parameter logic [XLEN-1:0] RESET_PC       = XLEN'(RESET_PC_DEF),
   parameter int unsigned     TIMEOUT_CYCLES = TIMEOUT_DEF
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              id_stall,
   input  logic              branch_taken,
   input  logic [XLEN-1:0]   branch_target,
   fetch_sequencer_if.master imem,
   output logic              IF_ID_write,
   output logic              IF_flush,
   output logic [XLEN-1:0]   fetch_pc,
   output logic [XLEN-1:0]   fetch_inst,
   output logic              misalign_err,
   output logic              bus_err
);

   localparam int unsigned     CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT_CYCLES);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
   localparam logic [XLEN-1:0]  PC_STEP  = XLEN'(32'd4);

   fetch_state_e     state_q, state_d;
   logic [XLEN-1:0]  pc_q, pc_d;
   logic             drop_q, drop_d;
   logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
   logic [XLEN-1:0]  buf_q, buf_d;
   logic             bus_err_q, bus_err_d;
   logic             if_id_write_q, if_id_write_d;
   logic [XLEN-1:0]  fetch_pc_q, fetch_pc_d;
   logic [XLEN-1:0]  fetch_inst_q, fetch_inst_d;
   logic             misalign_q, misalign_d;

   logic             redirect_s;
   logic [XLEN-1:0]  target_s;
   logic             deliver_s;
   logic [XLEN-1:0]  deliver_inst_s;

   // Redirects are ignored in IDLE; otherwise they pre-empt everything.
   assign redirect_s = branch_taken && (state_q != S_IDLE);
   assign target_s   = {branch_target[XLEN-1:2], 2'b00};

   // Next-state, PC, drop, timeout and delivery decisions.
   always_comb begin
      state_d        = state_q;
      pc_d           = pc_q;
      drop_d         = drop_q;
      wait_cnt_d     = wait_cnt_q;
      buf_d          = buf_q;
      bus_err_d      = bus_err_q;
      deliver_s      = 1'b0;
      deliver_inst_s = buf_q;
      case (state_q)
         S_IDLE: begin
            state_d = S_REQ;
         end
         S_REQ: begin
            if (redirect_s) begin
               pc_d = target_s;
            end else begin
               pc_d = pc_q;
            end
            if (imem.gnt) begin
               // A request granted in the redirect cycle carries the old
               // address, so its response must be thrown away.
               state_d    = S_WAIT;
               wait_cnt_d = '0;
               drop_d     = redirect_s;
            end else begin
               state_d = S_REQ;
            end
         end
         S_WAIT: begin
            if (wait_cnt_q != CNT_MAX) begin
               wait_cnt_d = wait_cnt_q + CNT_W'(1);
            end else begin
               wait_cnt_d = wait_cnt_q;
            end
            if (wait_cnt_q == CNT_LAST) begin
               bus_err_d = 1'b1;
            end else begin
               bus_err_d = bus_err_q;
            end
            if (redirect_s) begin
               pc_d = target_s;
               if (imem.rvalid) begin
                  drop_d  = 1'b0;
                  state_d = S_REQ;
               end else begin
                  drop_d  = 1'b1;
                  state_d = S_WAIT;
               end
            end else if (imem.rvalid) begin
               if (drop_q) begin
                  // pc_q already holds the redirect target.
                  drop_d  = 1'b0;
                  state_d = S_REQ;
               end else if (!id_stall) begin
                  buf_d          = imem.rdata;
                  deliver_s      = 1'b1;
                  deliver_inst_s = imem.rdata;
                  pc_d           = pc_q + PC_STEP;
                  state_d        = S_REQ;
               end else begin
                  buf_d   = imem.rdata;
                  state_d = S_HOLD;
               end
            end else begin
               state_d = S_WAIT;
            end
         end
         S_HOLD: begin
            if (redirect_s) begin
               pc_d    = target_s;
               buf_d   = '0;
               state_d = S_REQ;
            end else if (!id_stall) begin
               deliver_s      = 1'b1;
               deliver_inst_s = buf_q;
               pc_d           = pc_q + PC_STEP;
               state_d        = S_REQ;
            end else begin
               state_d = S_HOLD;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // Registered delivery outputs; fetch_pc/fetch_inst hold between deliveries.
   always_comb begin
      if_id_write_d = deliver_s;
      misalign_d    = redirect_s && (branch_target[1:0] != 2'b00);
      if (deliver_s) begin
         fetch_pc_d   = pc_q;
         fetch_inst_d = deliver_inst_s;
      end else begin
         fetch_pc_d   = fetch_pc_q;
         fetch_inst_d = fetch_inst_q;
      end
   end

   // State and output registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q       <= S_IDLE;
         pc_q          <= RESET_PC;
         drop_q        <= 1'b0;
         wait_cnt_q    <= '0;
         buf_q         <= '0;
         bus_err_q     <= 1'b0;
         if_id_write_q <= 1'b0;
         fetch_pc_q    <= '0;
         fetch_inst_q  <= '0;
         misalign_q    <= 1'b0;
      end else begin
         state_q       <= state_d;
         pc_q          <= pc_d;
         drop_q        <= drop_d;
         wait_cnt_q    <= wait_cnt_d;
         buf_q         <= buf_d;
         bus_err_q     <= bus_err_d;
         if_id_write_q <= if_id_write_d;
         fetch_pc_q    <= fetch_pc_d;
         fetch_inst_q  <= fetch_inst_d;
         misalign_q    <= misalign_d;
      end
   end

   assign imem.req     = (state_q == S_REQ);
   assign imem.addr    = (state_q == S_REQ) ? pc_q : '0;
   assign IF_flush     = redirect_s;
   // A write scheduled for the same cycle as a flush would load a wrong-path instruction.
   assign IF_ID_write  = if_id_write_q && !redirect_s;
   assign fetch_pc     = fetch_pc_q;
   assign fetch_inst   = fetch_inst_q;
   assign misalign_err = misalign_q;
   assign bus_err      = bus_err_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// ----------------------------------------------------------------------------
// tb_fetch_sequencer
//   Self-checking bench: directed scenarios plus randomized traffic. A
//   transaction-level reference model predicts delivered instructions into a
//   scoreboard queue; a negedge monitor compares DUT outputs against it.
// ----------------------------------------------------------------------------
module tb_fetch_sequencer;
   import fetch_sequencer_pkg::*;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        id_stall = 1'b0;
   logic        branch_taken = 1'b0;
   logic [31:0] branch_target = 32'h0;
   logic        IF_ID_write, IF_flush, misalign_err, bus_err;
   logic [31:0] fetch_pc, fetch_inst;

   fetch_sequencer_if #(.XLEN(32)) imem ();

   fetch_sequencer #(.XLEN(32), .RESET_PC(32'h0), .TIMEOUT_CYCLES(16)) dut (
      .clk(clk), .reset(reset), .id_stall(id_stall),
      .branch_taken(branch_taken), .branch_target(branch_target),
      .imem(imem), .IF_ID_write(IF_ID_write), .IF_flush(IF_flush),
      .fetch_pc(fetch_pc), .fetch_inst(fetch_inst),
      .misalign_err(misalign_err), .bus_err(bus_err)
   );

   always #5 clk = ~clk;

   // Reference model: where the fetch stream stands at transaction level.
   typedef enum {M_IDLE, M_ISSUE, M_OUT, M_HOLD} mph_e;
   typedef struct { logic [31:0] pc; logic [31:0] inst; } ent_t;

   mph_e        ph = M_IDLE;
   logic [31:0] m_pc = 32'h0, m_out_pc = 32'h0, held_pc = 32'h0, held_inst = 32'h0;
   logic [31:0] pend_pc = 32'h0, pend_inst = 32'h0;
   bit          m_drop = 1'b0, pend_v = 1'b0, m_bus = 1'b0, m_mis = 1'b0;
   int          m_wait = 0;
   bit          exp_req = 1'b0, exp_flush = 1'b0, exp_mis = 1'b0, exp_bus = 1'b0;
   logic [31:0] exp_addr = 32'h0;
   ent_t        exp_q[$];
   ent_t        mon_e;
   int          n_checks = 0, n_errors = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   // Drive one cycle of inputs, publish this cycle's expectations, advance the model.
   task automatic apply(input bit br, input logic [31:0] tgt, input bit stall,
                        input bit gnt, input bit rv, input logic [31:0] rd);
      bit          br_eff;
      logic [31:0] new_pc;
      branch_taken  = br;
      branch_target = tgt;
      id_stall      = stall;
      imem.gnt      = gnt;
      imem.rvalid   = rv;
      imem.rdata    = rd;
      br_eff    = br && (ph != M_IDLE);
      new_pc    = {tgt[31:2], 2'b00};
      exp_req   = (ph == M_ISSUE);
      exp_addr  = m_pc;
      exp_flush = br_eff;
      exp_mis   = m_mis;
      exp_bus   = m_bus;
      // A delivery shows up as a write one cycle later unless a redirect squashes it.
      if (pend_v && !br_eff) exp_q.push_back('{pend_pc, pend_inst});
      pend_v = 1'b0;
      m_mis  = br_eff && (tgt[1:0] != 2'b00);
      case (ph)
         M_IDLE: ph = M_ISSUE;
         M_ISSUE: begin
            if (gnt) begin
               m_out_pc = m_pc; m_drop = br_eff; m_wait = 0; ph = M_OUT;
            end
            if (br_eff) m_pc = new_pc;
         end
         M_OUT: begin
            m_wait++;
            if (m_wait == 16) m_bus = 1'b1;
            if (br_eff) begin
               m_pc = new_pc;
               if (rv) begin m_drop = 1'b0; ph = M_ISSUE; end
               else m_drop = 1'b1;
            end else if (rv) begin
               if (m_drop) begin
                  m_drop = 1'b0; ph = M_ISSUE;
               end else if (!stall) begin
                  pend_v = 1'b1; pend_pc = m_out_pc; pend_inst = rd;
                  m_pc = m_out_pc + 32'd4; ph = M_ISSUE;
               end else begin
                  held_pc = m_out_pc; held_inst = rd; ph = M_HOLD;
               end
            end
         end
         M_HOLD: begin
            if (br_eff) begin
               m_pc = new_pc; ph = M_ISSUE;
            end else if (!stall) begin
               pend_v = 1'b1; pend_pc = held_pc; pend_inst = held_inst;
               m_pc = held_pc + 32'd4; ph = M_ISSUE;
            end
         end
         default: ph = M_IDLE;
      endcase
   endtask

   // One cycle with protocol-legal gnt/rvalid (only where the model expects them).
   task automatic auto(input bit br, input logic [31:0] tgt, input bit stall,
                       input bit gnt_ok, input bit rv_ok, input logic [31:0] rd);
      @(posedge clk); #1;
      apply(br, tgt, stall, gnt_ok && (ph == M_ISSUE), rv_ok && (ph == M_OUT), rd);
   endtask

   task automatic do_reset(input bit late_rv);
      @(posedge clk); #1;
      reset = 1'b1;
      branch_taken = 1'b0; id_stall = 1'b0; imem.gnt = 1'b0; imem.rvalid = 1'b0;
      ph = M_IDLE; m_pc = 32'h0; m_drop = 1'b0; pend_v = 1'b0; m_bus = 1'b0;
      m_mis = 1'b0; m_wait = 0; exp_q.delete();
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      // First cycle after release is IDLE; a stale rvalid here must be ignored.
      apply(1'b0, 32'h0, 1'b0, 1'b0, late_rv, 32'hDEAD_BEEF);
   endtask

   task automatic goto_out();
      for (int i = 0; i < 12 && ph != M_OUT; i++) auto(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, $urandom);
   endtask

   task automatic goto_issue();
      for (int i = 0; i < 12 && ph != M_ISSUE; i++) auto(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, $urandom);
   endtask

   // Monitor: compare DUT outputs against published expectations and the scoreboard.
   always @(negedge clk) begin
      if (reset) begin
         chk("rst_req", {31'h0, imem.req}, 32'h0);
         chk("rst_addr", imem.addr, 32'h0);
         chk("rst_write", {31'h0, IF_ID_write}, 32'h0);
         chk("rst_flush", {31'h0, IF_flush}, 32'h0);
         chk("rst_fetch_pc", fetch_pc, 32'h0);
         chk("rst_fetch_inst", fetch_inst, 32'h0);
         chk("rst_misalign", {31'h0, misalign_err}, 32'h0);
         chk("rst_bus_err", {31'h0, bus_err}, 32'h0);
      end else begin
         chk("imem_req", {31'h0, imem.req}, {31'h0, exp_req});
         if (exp_req) chk("imem_addr", imem.addr, exp_addr);
         chk("if_flush", {31'h0, IF_flush}, {31'h0, exp_flush});
         chk("misalign_err", {31'h0, misalign_err}, {31'h0, exp_mis});
         chk("bus_err", {31'h0, bus_err}, {31'h0, exp_bus});
         if (IF_ID_write) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_write", {31'h0, IF_ID_write}, 32'h0);
            end else begin
               mon_e = exp_q.pop_front();
               chk("fetch_pc", fetch_pc, mon_e.pc);
               chk("fetch_inst", fetch_inst, mon_e.inst);
            end
         end else if (exp_q.size() != 0) begin
            chk("missing_write", {31'h0, IF_ID_write}, 32'h1);
            exp_q.delete();
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] tgt;
      imem.gnt = 1'b0; imem.rvalid = 1'b0; imem.rdata = 32'h0;
      do_reset(1'b0);

      // Back-to-back fetches with gnt in REQ and rvalid next cycle.
      repeat (8) auto(1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 32'h00E6_0433);

      // ID stall across the response: HOLD, then a single delivery on release.
      goto_out();
      auto(1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 32'h1111_2222);
      repeat (2) auto(1'b0, 32'h0, 1'b1, 1'b1, 1'b1, $urandom);
      repeat (4) auto(1'b0, 32'h0, 1'b0, 1'b1, 1'b1, $urandom);

      // Redirect in WAIT with the response arriving later: response dropped.
      goto_out();
      auto(1'b1, 32'h0000_0040, 1'b0, 1'b0, 1'b0, $urandom);
      auto(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, $urandom);
      auto(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 32'hBAD0_0001);
      repeat (4) auto(1'b0, 32'h0, 1'b0, 1'b1, 1'b1, $urandom);

      // Misaligned redirect coinciding with rvalid.
      goto_out();
      auto(1'b1, 32'h0000_0042, 1'b0, 1'b0, 1'b1, 32'hBAD0_0002);
      repeat (4) auto(1'b0, 32'h0, 1'b0, 1'b1, 1'b1, $urandom);

      // PC wrap at the top of the address space, then a long gnt-low stretch.
      goto_issue();
      auto(1'b1, 32'hFFFF_FFFC, 1'b0, 1'b0, 1'b0, $urandom);
      auto(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, $urandom);
      auto(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 32'h0BAD_F00D);
      repeat (5) auto(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, $urandom);
      repeat (4) auto(1'b0, 32'h0, 1'b0, 1'b1, 1'b1, $urandom);

      // Randomized traffic.
      for (int i = 0; i < 3000; i++) begin
         tgt = ($urandom & 32'h0000_03FF) | ((($urandom % 8) == 0) ? 32'hFFFF_FC00 : 32'h0);
         auto((($urandom % 12) == 0), tgt, (($urandom % 3) == 0),
              (($urandom % 2) == 0), (($urandom % 3) != 0), $urandom);
      end

      // Response never arrives: bus_err becomes sticky; reset mid-WAIT clears it.
      goto_out();
      repeat (20) auto(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, $urandom);
      do_reset(1'b1);
      repeat (6) auto(1'b0, 32'h0, 1'b0, 1'b1, 1'b1, $urandom);

      // Drain and confirm nothing predicted was left undelivered.
      repeat (4) auto(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, $urandom);
      @(negedge clk); #1;
      chk("scoreboard_drained", exp_q.size(), 32'h0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
